// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared widths, control-bit indices and helper types for the
//               MIPS pipeline-stage registers (ID/EX, EX/MEM, MEM/WB).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Datapath field widths
  localparam int PC_W       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  // EX/MEM control bit positions
  localparam int CTL_JAL      = 0;
  localparam int CTL_MEMREAD  = 1;
  localparam int CTL_MEMTOREG = 2;
  localparam int CTL_MEMWRITE = 3;
  localparam int CTL_REGWRITE = 4;

  // Per-stage bundle widths
  localparam int EXMEM_DATA_W = PC_W + WORD_W + REG_ADDR_W + WORD_W;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_DATA_W = PC_W + WORD_W + REG_ADDR_W + WORD_W;
  localparam int MEMWB_CTRL_W = 3;

  // EX/MEM data bundle layout, ALUResult in the least significant bits
  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [WORD_W-1:0]     read_data2;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [WORD_W-1:0]     alu_result;
  } exmem_data_t;

  // Per-cycle operation applied to one storage slot
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,  // keep everything
    SLOT_LOAD  = 2'd1,  // capture new data/ctrl, become valid
    SLOT_DROP  = 2'd2,  // become invalid, keep last contents
    SLOT_CLEAR = 2'd3   // become invalid, zero contents
  } slot_op_e;

  // Number of occupied entries from the two slot valid bits
  function automatic logic [1:0] entry_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline storage entry: valid bit plus data and control
//               registers, driven by a per-cycle slot operation.
// Ports       : clk, reset (async, active-low), op (hold/load/drop/clear),
//               in_data/in_ctrl (load source), valid/data/ctrl (contents)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  slot_op_e          op,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    case (op)
      SLOT_LOAD: begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end
      SLOT_DROP: begin
        valid_d = 1'b0;
      end
      SLOT_CLEAR: begin
        valid_d = 1'b0;
        data_d  = '0;
        ctrl_d  = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Parametrised pipeline-stage register with valid/ready
//               handshake, flush and optional 2-entry skid buffer. Bubbles
//               never present asserted control bits.
// Ports       : clk, reset (async, active-low), flush,
//               in_valid/in_ready/in_data/in_ctrl   (upstream),
//               out_valid/out_ready/out_data/out_ctrl (downstream),
//               count (entries held)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  slot_op_e          main_op;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic              push;
  logic              pop;

  assign push = in_valid && in_ready;
  assign pop  = main_valid && out_ready;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .op      (main_op),
    .in_data (main_src_data),
    .in_ctrl (main_src_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      slot_op_e          skid_op;

      // The skid only ever fills while main is full, so main empty implies
      // skid empty. When main pops, the older skid entry always wins over a
      // new input; in_ready is low whenever the skid is full, so both never
      // compete.
      always_comb begin
        main_op       = SLOT_HOLD;
        skid_op       = SLOT_HOLD;
        main_src_data = in_data;
        main_src_ctrl = in_ctrl;
        if (flush) begin
          main_op = SLOT_CLEAR;
          skid_op = SLOT_CLEAR;
        end else if (!main_valid) begin
          if (push) begin
            main_op = SLOT_LOAD;
          end
        end else if (pop) begin
          if (skid_valid) begin
            main_op       = SLOT_LOAD;
            main_src_data = skid_data;
            main_src_ctrl = skid_ctrl;
            skid_op       = SLOT_DROP;
          end else if (push) begin
            main_op = SLOT_LOAD;
          end else begin
            main_op = SLOT_DROP;
          end
        end else if (push) begin
          skid_op = SLOT_LOAD;
        end
      end

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .op      (skid_op),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
      );

      // Straight from a flop: no combinational path from out_ready upstream
      assign in_ready = !skid_valid;
      assign count    = entry_count(main_valid, skid_valid);
    end else begin : g_no_skid
      always_comb begin
        main_op       = SLOT_HOLD;
        main_src_data = in_data;
        main_src_ctrl = in_ctrl;
        if (flush) begin
          main_op = SLOT_CLEAR;
        end else if (push) begin
          main_op = SLOT_LOAD;
        end else if (pop) begin
          main_op = SLOT_DROP;
        end
      end

      assign in_ready = out_ready || !main_valid;
      assign count    = entry_count(main_valid, 1'b0);
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  // A bubble must never carry RegWrite/MemWrite downstream
  assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. Drives an SKID=1
//               and an SKID=0 instance from the same inputs; directed vector
//               table, hand-written reset/combinational-ready sequences and a
//               randomised run against queue scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = EXMEM_DATA_W;
  localparam int CW = EXMEM_CTRL_W;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;

  logic          in_ready,  out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    count;

  logic          in_ready0, out_valid0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] out_ctrl0;
  logic [1:0]    count0;

  int passed = 0;
  int total  = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .count     (count)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .out_ctrl  (out_ctrl0),
    .count     (count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [1:0]    en;
    logic          er;
  } vec_t;

  function automatic vec_t mk(input int fl, input int iv, input int d, input int c, input int ordy,
                              input int ev, input int ed, input int ec, input int en, input int er);
    vec_t v;
    v.fl   = (fl != 0);
    v.iv   = (iv != 0);
    v.d    = DW'(d);
    v.c    = CW'(c);
    v.ordy = (ordy != 0);
    v.ev   = (ev != 0);
    v.ed   = DW'(ed);
    v.ec   = CW'(ec);
    v.en   = 2'(en);
    v.er   = (er != 0);
    return v;
  endfunction

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
  endtask

  initial begin
    vec_t          vecs[15];
    logic [127:0]  r;
    logic          e_ir1, e_ir0;
    ent_t          e;

    // inputs: flush, in_valid, data, ctrl, out_ready
    // expect after edge: out_valid, out_data, out_ctrl, count, in_ready
    vecs[0]  = mk(0, 0, 'h00, 'h00, 1,  0, 'h00, 'h00, 0, 1);
    vecs[1]  = mk(0, 1, 'h10, 'h10, 1,  1, 'h10, 'h10, 1, 1);  // stream
    vecs[2]  = mk(0, 1, 'h20, 'h11, 1,  1, 'h20, 'h11, 1, 1);
    vecs[3]  = mk(0, 1, 'h30, 'h12, 1,  1, 'h30, 'h12, 1, 1);
    vecs[4]  = mk(0, 0, 'h00, 'h00, 1,  0, 'h30, 'h00, 0, 1);  // drain, bubble ctrl=0
    vecs[5]  = mk(0, 1, 'hA0, 'h18, 0,  1, 'hA0, 'h18, 1, 1);  // A, stalled
    vecs[6]  = mk(0, 1, 'hB0, 'h08, 0,  1, 'hA0, 'h18, 2, 0);  // B into skid
    vecs[7]  = mk(0, 1, 'hEE, 'h1F, 0,  1, 'hA0, 'h18, 2, 0);  // refused, A held
    vecs[8]  = mk(0, 1, 'hEE, 'h1F, 1,  1, 'hB0, 'h08, 1, 1);  // A pops, B moves up
    vecs[9]  = mk(0, 1, 'hC0, 'h14, 1,  1, 'hC0, 'h14, 1, 1);  // push C / pop B
    vecs[10] = mk(0, 1, 'hD0, 'h18, 0,  1, 'hC0, 'h14, 2, 0);
    vecs[11] = mk(1, 1, 'hFF, 'h1F, 0,  0, 'h00, 'h00, 0, 1);  // flush w/ offer
    vecs[12] = mk(0, 0, 'h00, 'h00, 1,  0, 'h00, 'h00, 0, 1);
    vecs[13] = mk(0, 1, 'h55, 'h10, 1,  1, 'h55, 'h10, 1, 1);
    vecs[14] = mk(1, 1, 'h66, 'h1F, 1,  0, 'h00, 'h00, 0, 1);  // flush beats push/pop

    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #2;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_data",  128'(out_data),  128'(0));
    check("reset_out_ctrl",  128'(out_ctrl),  128'(0));
    check("reset_count",     128'(count),     128'(0));
    check("reset_in_ready",  128'(in_ready),  128'(1));
    check("reset_in_ready0", 128'(in_ready0), 128'(1));
    #10;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].ev));
      check($sformatf("vec%0d_out_data", i),  128'(out_data),  128'(vecs[i].ed));
      check($sformatf("vec%0d_out_ctrl", i),  128'(out_ctrl),  128'(vecs[i].ec));
      check($sformatf("vec%0d_count", i),     128'(count),     128'(vecs[i].en));
      check($sformatf("vec%0d_in_ready", i),  128'(in_ready),  128'(vecs[i].er));
    end

    // Async reset with two entries held, checked before any clock edge
    drive(1'b0, 1'b1, DW'('h71), CW'('h18), 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, DW'('h72), CW'('h18), 1'b0);
    @(posedge clk); #1;
    check("pre_async_count", 128'(count), 128'(2));
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 128'(out_valid), 128'(0));
    check("async_out_ctrl",  128'(out_ctrl),  128'(0));
    check("async_count",     128'(count),     128'(0));
    check("async_in_ready",  128'(in_ready),  128'(1));
    #3;
    reset = 1'b1;
    drive(1'b0, 1'b1, DW'('h77), CW'('h10), 1'b0);
    @(posedge clk); #1;
    check("post_reset_out_valid", 128'(out_valid), 128'(1));
    check("post_reset_out_data",  128'(out_data),  128'('h77));
    check("post_reset_count",     128'(count),     128'(1));

    // SKID=0: combinational in_ready follows out_ready with the entry full
    drive(1'b0, 1'b1, DW'('h88), CW'('h01), 1'b0);
    #1;
    check("skid0_full_stall_in_ready", 128'(in_ready0), 128'(0));
    out_ready = 1'b1;
    #1;
    check("skid0_full_ready_in_ready", 128'(in_ready0), 128'(1));
    @(posedge clk); #1;
    check("skid0_replace_out_data", 128'(out_data0), 128'('h88));
    check("skid0_replace_out_ctrl", 128'(out_ctrl0), 128'('h01));
    check("skid0_replace_count",    128'(count0),    128'(1));

    // Randomised traffic against queue scoreboards, both builds
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #2;
    reset = 1'b0;
    #4;
    reset = 1'b1;
    q1.delete();
    q0.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), r[DW-1:0],
            CW'($urandom()), 1'($urandom_range(0, 1)));
      #1;
      e_ir1 = (q1.size() < 2);
      e_ir0 = out_ready || (q0.size() == 0);
      check("rand_in_ready_skid1", 128'(in_ready),  128'(e_ir1));
      check("rand_in_ready_skid0", 128'(in_ready0), 128'(e_ir0));
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() > 0 && out_ready) e = q1.pop_front();
        if (in_valid && e_ir1) q1.push_back({in_data, in_ctrl});
        if (q0.size() > 0 && out_ready) e = q0.pop_front();
        if (in_valid && e_ir0) q0.push_back({in_data, in_ctrl});
      end
      @(posedge clk); #1;
      check("rand_out_valid_skid1", 128'(out_valid), 128'(q1.size() > 0));
      check("rand_count_skid1",     128'(count),     128'(q1.size()));
      check("rand_out_ctrl_skid1",  128'(out_ctrl),  128'((q1.size() > 0) ? q1[0].c : CW'(0)));
      if (q1.size() > 0) check("rand_out_data_skid1", 128'(out_data), 128'(q1[0].d));
      check("rand_out_valid_skid0", 128'(out_valid0), 128'(q0.size() > 0));
      check("rand_count_skid0",     128'(count0),     128'(q0.size()));
      check("rand_out_ctrl_skid0",  128'(out_ctrl0),  128'((q0.size() > 0) ? q0[0].c : CW'(0)));
      if (q0.size() > 0) check("rand_out_data_skid0", 128'(out_data0), 128'(q0[0].d));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
